// File: rtl/vga_fetch_arbiter.sv
// vga_fetch_arbiter
//   Shares the single video-memory port between the CPU bus and the VGA
//   line refill engine. Once per scanline (counter_x == FETCH_X) a burst of
//   LINE_WORDS reads is scheduled into the idle half of a ping-pong line
//   buffer. CPU single-word accesses use the port between bursts. Video
//   refill always has priority, but a CPU access in flight is never
//   preempted.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   counter_x/counter_y  pixel counters from the sync generator
//   vid_base             frame base address, sampled on the frame trigger
//   cpu_*                CPU request side (cpu_req held until cpu_ack pulse)
//   mem_*                memory port (mem_req held until mem_ack)
//   lb_*                 line-buffer write port and fill-bank select
//   underrun             sticky: trigger arrived before the burst finished
//   dbg_state_o          current arbiter state (debug visibility)
//
// Handshake: mem_req rises the cycle after the grant, and mem_we/mem_adr/
// mem_dat_o stay stable until a cycle in which mem_ack is sampled high.
// mem_req drops the following cycle, so each word takes at least two
// cycles. cpu_req/cpu_we/cpu_adr/cpu_dat_i are held until cpu_ack, which
// pulses for exactly one cycle with cpu_dat_o valid.

module vga_fetch_arbiter #(
  parameter int          ADDR_W       = 16,
  parameter int          LINE_WORDS   = 40,
  parameter int          LINE_STRIDE  = 40,
  parameter int          ACTIVE_LINES = 480,
  parameter logic [9:0]  FETCH_X      = 10'd320
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        counter_x,
  input  logic [8:0]        counter_y,
  input  logic [ADDR_W-1:0] vid_base,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_adr,
  input  logic [15:0]       cpu_dat_i,
  output logic              cpu_ack,
  output logic [15:0]       cpu_dat_o,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [15:0]       mem_dat_o,
  input  logic              mem_ack,
  input  logic [15:0]       mem_dat_i,
  output logic              lb_we,
  output logic [5:0]        lb_waddr,
  output logic [15:0]       lb_wdata,
  output logic              lb_fill_bank,
  output logic              underrun,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_VID = 2'd1, ST_CPU = 2'd2} state_t;

  localparam logic [5:0]        LAST_IDX = 6'(LINE_WORDS - 1);
  localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(LINE_STRIDE);
  localparam logic [9:0]        ACT_L    = 10'(ACTIVE_LINES);

  state_t              state_q, state_d;
  logic                vid_pending_q, vid_pending_d;
  logic [ADDR_W-1:0]   line_adr_q, line_adr_d;
  logic [5:0]          idx_q, idx_d;          // next word of the current line
  logic [5:0]          cur_idx_q, cur_idx_d;  // word currently on the port
  logic                stale_q, stale_d;      // a trigger hit during this word
  logic                bank_q, bank_d;
  logic                underrun_q, underrun_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [15:0]         dat_q, dat_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic [15:0]         cpu_dat_q, cpu_dat_d;
  logic                lb_we_q, lb_we_d;
  logic [5:0]          lb_waddr_q, lb_waddr_d;
  logic [15:0]         lb_wdata_q, lb_wdata_d;

  logic frame_trig;
  logic trig;

  assign frame_trig = (counter_y == 9'd511);
  assign trig = (counter_x == FETCH_X) &&
                (frame_trig || (({1'b0, counter_y} + 10'd1) < ACT_L));

  always_comb begin
    state_d       = state_q;
    vid_pending_d = vid_pending_q;
    line_adr_d    = line_adr_q;
    idx_d         = idx_q;
    cur_idx_d     = cur_idx_q;
    stale_d       = stale_q;
    bank_d        = bank_q;
    underrun_d    = underrun_q;
    we_d          = we_q;
    adr_d         = adr_q;
    dat_d         = dat_q;
    cpu_ack_d     = 1'b0;
    cpu_dat_d     = cpu_dat_q;
    lb_we_d       = 1'b0;
    lb_waddr_d    = lb_waddr_q;
    lb_wdata_d    = lb_wdata_q;

    if (trig) begin
      bank_d        = ~bank_q;
      vid_pending_d = 1'b1;
      idx_d         = 6'd0;
      line_adr_d    = frame_trig ? vid_base : line_adr_q + STRIDE;
      if (vid_pending_q)      underrun_d = 1'b1;
      // The word on the port belongs to the old line: let it finish, but
      // it must not advance the restarted burst.
      if (state_q == ST_VID)  stale_d    = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        // A trigger in this very cycle counts as pending, so a CPU request
        // arriving together with it waits behind the burst.
        if (vid_pending_q || trig) begin
          state_d   = ST_VID;
          adr_d     = line_adr_d + {{(ADDR_W-6){1'b0}}, idx_d};
          we_d      = 1'b0;
          dat_d     = 16'd0;
          cur_idx_d = idx_d;
          stale_d   = 1'b0;
        end else if (cpu_req && !cpu_ack_q) begin
          // cpu_ack_q blocks a re-grant while the master still holds
          // cpu_req in the ack cycle.
          state_d = ST_CPU;
          adr_d   = cpu_adr;
          we_d    = cpu_we;
          dat_d   = cpu_we ? cpu_dat_i : 16'd0;
        end
      end
      ST_VID: begin
        if (mem_ack) begin
          lb_we_d    = 1'b1;
          lb_waddr_d = cur_idx_q;
          lb_wdata_d = mem_dat_i;
          state_d    = ST_IDLE;
          we_d       = 1'b0;
          adr_d      = '0;
          dat_d      = 16'd0;
          if (!trig && !stale_q) begin
            if (cur_idx_q == LAST_IDX) vid_pending_d = 1'b0;
            else                       idx_d         = cur_idx_q + 6'd1;
          end
        end
      end
      ST_CPU: begin
        if (mem_ack) begin
          cpu_ack_d = 1'b1;
          cpu_dat_d = mem_dat_i;
          state_d   = ST_IDLE;
          we_d      = 1'b0;
          adr_d     = '0;
          dat_d     = 16'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      vid_pending_q <= 1'b0;
      line_adr_q    <= '0;
      idx_q         <= 6'd0;
      cur_idx_q     <= 6'd0;
      stale_q       <= 1'b0;
      bank_q        <= 1'b0;
      underrun_q    <= 1'b0;
      we_q          <= 1'b0;
      adr_q         <= '0;
      dat_q         <= 16'd0;
      cpu_ack_q     <= 1'b0;
      cpu_dat_q     <= 16'd0;
      lb_we_q       <= 1'b0;
      lb_waddr_q    <= 6'd0;
      lb_wdata_q    <= 16'd0;
    end else begin
      state_q       <= state_d;
      vid_pending_q <= vid_pending_d;
      line_adr_q    <= line_adr_d;
      idx_q         <= idx_d;
      cur_idx_q     <= cur_idx_d;
      stale_q       <= stale_d;
      bank_q        <= bank_d;
      underrun_q    <= underrun_d;
      we_q          <= we_d;
      adr_q         <= adr_d;
      dat_q         <= dat_d;
      cpu_ack_q     <= cpu_ack_d;
      cpu_dat_q     <= cpu_dat_d;
      lb_we_q       <= lb_we_d;
      lb_waddr_q    <= lb_waddr_d;
      lb_wdata_q    <= lb_wdata_d;
    end
  end

  assign mem_req      = (state_q != ST_IDLE);
  assign mem_we       = we_q;
  assign mem_adr      = adr_q;
  assign mem_dat_o    = dat_q;
  assign cpu_ack      = cpu_ack_q;
  assign cpu_dat_o    = cpu_dat_q;
  assign lb_we        = lb_we_q;
  assign lb_waddr     = lb_waddr_q;
  assign lb_wdata     = lb_wdata_q;
  assign lb_fill_bank = bank_q;
  assign underrun     = underrun_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_vga_fetch_arbiter.sv
// tb_vga_fetch_arbiter
//   Directed bench for vga_fetch_arbiter. A memory model answers requests
//   with data = address ^ 16'h5A5A after a programmable delay (or holds one
//   address stalled). Expected memory requests, line-buffer writes and CPU
//   read data are queued by the stimulus; a monitor pops and compares them
//   as the DUT presents them.

module tb_vga_fetch_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  counter_x;
  logic [8:0]  counter_y;
  logic [15:0] vid_base;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_adr, cpu_dat_i;
  logic        cpu_ack;
  logic [15:0] cpu_dat_o;
  logic        mem_req, mem_we;
  logic [15:0] mem_adr, mem_dat_o;
  logic        mem_ack;
  logic [15:0] mem_dat_i;
  logic        lb_we;
  logic [5:0]  lb_waddr;
  logic [15:0] lb_wdata;
  logic        lb_fill_bank;
  logic        underrun;
  logic [1:0]  dbg_state;

  vga_fetch_arbiter dut (
    .clk(clk), .rst(rst), .counter_x(counter_x), .counter_y(counter_y),
    .vid_base(vid_base), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_adr(cpu_adr), .cpu_dat_i(cpu_dat_i), .cpu_ack(cpu_ack),
    .cpu_dat_o(cpu_dat_o), .mem_req(mem_req), .mem_we(mem_we),
    .mem_adr(mem_adr), .mem_dat_o(mem_dat_o), .mem_ack(mem_ack),
    .mem_dat_i(mem_dat_i), .lb_we(lb_we), .lb_waddr(lb_waddr),
    .lb_wdata(lb_wdata), .lb_fill_bank(lb_fill_bank), .underrun(underrun),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int vectors     = 0;
  int miscompares = 0;
  int lb_cnt      = 0;
  int cpu_ack_cnt = 0;
  logic mon_en    = 1'b1;

  logic [32:0] exp_req_q[$];  // {we, adr, dat}
  logic [21:0] exp_lb_q[$];   // {waddr, wdata}
  logic [15:0] exp_cpu_q[$];  // cpu_dat_o

  function automatic logic [15:0] mdata(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  int          ack_delay = 0;
  int          stall     = 0;
  logic        hold_en   = 1'b0;
  logic [15:0] hold_adr  = 16'h0;

  initial begin
    mem_ack   = 1'b0;
    mem_dat_i = 16'h0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req && !mem_ack && !(hold_en && mem_adr == hold_adr) && stall >= ack_delay) begin
        mem_ack   = 1'b1;
        mem_dat_i = mdata(mem_adr);
        stall     = 0;
      end else begin
        mem_ack = 1'b0;
        if (mem_req) stall++;
        else         stall = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  logic        prev_req = 1'b0;
  logic [32:0] e_req;
  logic [21:0] e_lb;
  logic [15:0] e_cpu;

  always @(negedge clk) begin
    if (mon_en && mem_req && !prev_req) begin
      if (exp_req_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL mem_req_unexpected: adr %0h we %0b, none expected", mem_adr, mem_we);
      end else begin
        e_req = exp_req_q.pop_front();
        check("mem_req_fields", {31'd0, mem_we, mem_adr, mem_dat_o}, {31'd0, e_req});
      end
    end
    prev_req = mem_req;
    if (mon_en && lb_we) begin
      lb_cnt++;
      if (exp_lb_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL lb_write_unexpected: waddr %0d data %0h, none expected", lb_waddr, lb_wdata);
      end else begin
        e_lb = exp_lb_q.pop_front();
        check("lb_write", {42'd0, lb_waddr, lb_wdata}, {42'd0, e_lb});
      end
    end
    if (mon_en && cpu_ack) begin
      cpu_ack_cnt++;
      if (exp_cpu_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL cpu_ack_unexpected: data %0h, none expected", cpu_dat_o);
      end else begin
        e_cpu = exp_cpu_q.pop_front();
        check("cpu_dat_o", {48'd0, cpu_dat_o}, {48'd0, e_cpu});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic trigger(input logic [8:0] y);
    @(negedge clk);
    counter_y = y;
    counter_x = 10'd320;
    @(negedge clk);
    counter_x = 10'd0;
  endtask

  task automatic push_line(input logic [15:0] base, input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      exp_req_q.push_back({1'b0, base + 16'(i), 16'h0});
      exp_lb_q.push_back({6'(i), mdata(base + 16'(i))});
    end
  endtask

  task automatic cpu_access(input logic we, input logic [15:0] adr, input logic [15:0] dat);
    @(negedge clk);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_adr   = adr;
    cpu_dat_i = dat;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (cpu_ack) break;
    end
    check("cpu_ack_seen", {63'd0, cpu_ack}, 64'd1);
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_dat_i = 16'h0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_req_q.size() != 0 || exp_lb_q.size() != 0 || exp_cpu_q.size() != 0 ||
            mem_req || cpu_req) && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("drain_left", 64'(exp_req_q.size() + exp_lb_q.size() + exp_cpu_q.size()), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  int base_lb;
  int base_ack;

  initial begin
    rst       = 1'b1;
    counter_x = 10'd0;
    counter_y = 9'd0;
    vid_base  = 16'h1000;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_adr   = 16'h0;
    cpu_dat_i = 16'h0;

    repeat (3) @(negedge clk);
    check("rst_mem_req",   {63'd0, mem_req},      64'd0);
    check("rst_mem_we",    {63'd0, mem_we},       64'd0);
    check("rst_mem_adr",   {48'd0, mem_adr},      64'd0);
    check("rst_mem_dat_o", {48'd0, mem_dat_o},    64'd0);
    check("rst_cpu_ack",   {63'd0, cpu_ack},      64'd0);
    check("rst_cpu_dat_o", {48'd0, cpu_dat_o},    64'd0);
    check("rst_lb",        {40'd0, lb_we, lb_waddr, lb_wdata}, 64'd0);
    check("rst_bank",      {63'd0, lb_fill_bank}, 64'd0);
    check("rst_underrun",  {63'd0, underrun},     64'd0);
    check("rst_state",     {62'd0, dbg_state},    64'd0);
    rst = 1'b0;

    // No trigger: y=479 would fetch line 480; x=319 is off the fetch column.
    @(negedge clk); counter_y = 9'd479; counter_x = 10'd320;
    @(negedge clk); counter_y = 9'd10;  counter_x = 10'd319;
    @(negedge clk); counter_x = 10'd0;
    repeat (4) @(negedge clk);
    check("notrig_bank",    {63'd0, lb_fill_bank}, 64'd0);
    check("notrig_mem_req", {63'd0, mem_req},      64'd0);

    // Line trigger y=10 after reset: line_adr 0 + 40 = 40, words 40..79.
    base_lb = lb_cnt;
    push_line(16'd40, 0, 40);
    trigger(9'd10);
    check("t1_bank", {63'd0, lb_fill_bank}, 64'd1);
    wait_drain(400);
    check("t1_lb_count", 64'(lb_cnt - base_lb), 64'd40);

    // Frame trigger: base 0x1000, then next line at 0x1028.
    push_line(16'h1000, 0, 40);
    trigger(9'd511);
    check("t2_bank", {63'd0, lb_fill_bank}, 64'd0);
    wait_drain(400);
    push_line(16'h1028, 0, 40);
    trigger(9'd0);
    wait_drain(400);

    // CPU read arrives with the trigger: the 40-word burst goes first.
    base_ack = cpu_ack_cnt;
    push_line(16'h1050, 0, 40);
    exp_req_q.push_back({1'b0, 16'h0200, 16'h0});
    exp_cpu_q.push_back(mdata(16'h0200));
    fork
      trigger(9'd1);
      cpu_access(1'b0, 16'h0200, 16'h0);
    join
    wait_drain(400);
    check("t3_ack_count", 64'(cpu_ack_cnt - base_ack), 64'd1);

    // CPU write in flight when the trigger hits: the write finishes first.
    base_ack  = cpu_ack_cnt;
    ack_delay = 5;
    exp_req_q.push_back({1'b1, 16'h0300, 16'hBEEF});
    exp_cpu_q.push_back(mdata(16'h0300));
    push_line(16'h1078, 0, 40);
    fork
      cpu_access(1'b1, 16'h0300, 16'hBEEF);
      begin
        repeat (3) @(negedge clk);
        trigger(9'd2);
      end
    join
    ack_delay = 0;
    wait_drain(600);
    check("t4_ack_count", 64'(cpu_ack_cnt - base_ack), 64'd1);
    check("t4_underrun",  {63'd0, underrun}, 64'd0);

    // Underrun: word 3 of line 0x10A0 stalls past the next trigger.
    hold_adr = 16'h10A3;
    hold_en  = 1'b1;
    push_line(16'h10A0, 0, 4);
    push_line(16'h10C8, 0, 40);
    trigger(9'd3);
    repeat (20) @(negedge clk);
    check("t5_stalled_adr", {47'd0, mem_req, mem_adr}, {47'd0, 1'b1, 16'h10A3});
    check("t5_underrun_pre", {63'd0, underrun}, 64'd0);
    trigger(9'd4);
    check("t5_underrun", {63'd0, underrun}, 64'd1);
    hold_en = 1'b0;
    wait_drain(400);
    check("t5_underrun_sticky", {63'd0, underrun}, 64'd1);

    // Asynchronous reset in the middle of a stalled burst.
    mon_en   = 1'b0;
    hold_adr = 16'h10F3;
    hold_en  = 1'b1;
    trigger(9'd5);
    repeat (12) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_mem_req",  {63'd0, mem_req},      64'd0);
    check("arst_mem_adr",  {48'd0, mem_adr},      64'd0);
    check("arst_underrun", {63'd0, underrun},     64'd0);
    check("arst_bank",     {63'd0, lb_fill_bank}, 64'd0);
    check("arst_state",    {62'd0, dbg_state},    64'd0);
    hold_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_req_q.delete();
    exp_lb_q.delete();
    exp_cpu_q.delete();
    @(negedge clk);
    mon_en = 1'b1;

    // After reset the next line trigger starts from line_adr 0 again.
    base_lb = lb_cnt;
    push_line(16'd40, 0, 40);
    trigger(9'd20);
    check("t6_bank", {63'd0, lb_fill_bank}, 64'd1);
    wait_drain(400);
    check("t6_lb_count", 64'(lb_cnt - base_lb), 64'd40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
